// File: rtl/handshake_initiator.sv
// handshake_initiator: queues job starts and drives the four-phase request/accept/done handshake.
// Optional timeout with DRAIN recovery under `HANDSHAKE_INITIATOR_TIMEOUT_EN.
module handshake_initiator #(
    parameter int HOLD_CYCLES = 2,
    parameter int TIMEOUT     = 16,
    parameter int MAX_PENDING = 4,
    parameter int ID_W        = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               start_drop,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending_count,
    output logic                               busy,
    output logic                               request,
    input  logic                               accept,
    input  logic                               done,
    output logic                               xfer_done,
    output logic [ID_W-1:0]                    xfer_id,
    output logic                               timeout_err
);
    localparam int PW = $clog2(MAX_PENDING+1);
    localparam int HW = $clog2(HOLD_CYCLES+1);

    typedef enum logic [2:0] {
        IDLE, REQ, HOLD, WAIT_DONE
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
        , DRAIN
`endif
    } state_t;

    state_t          state, state_n;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [PW-1:0]   pend_n;
    logic [ID_W-1:0] next_id;
    logic            issue, done_ev, full, drop;

    assign full = pending_count == PW'(MAX_PENDING);
    assign drop = start && !issue && full;
    assign busy = state != IDLE || pending_count != '0;
    assign pend_n = (start && !issue && !full) ? pending_count + PW'(1) :
                    (issue && !start)          ? pending_count - PW'(1) : pending_count;

`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic          to_ev, limit;
    assign limit = tcnt == TW'(TIMEOUT-1);
`endif

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        issue   = 1'b0;
        done_ev = 1'b0;
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
        to_ev   = 1'b0;
        tcnt_n  = tcnt + TW'(1);
`endif
        case (state)
            IDLE: if (pending_count != '0) begin
                state_n = REQ;
                issue   = 1'b1;
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end
            // accept sampled on the limit cycle wins over the timeout
            REQ: if (accept) begin
                state_n = HOLD;
                hold_n  = HW'(HOLD_CYCLES);
            end
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
            else if (limit) begin
                state_n = DRAIN;
                to_ev   = 1'b1;
                tcnt_n  = '0;
            end
`endif
            HOLD: if (hold_cnt == HW'(1)) begin
                state_n = WAIT_DONE;
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
                tcnt_n  = '0;
`endif
            end else begin
                hold_n  = hold_cnt - HW'(1);
            end
            WAIT_DONE: if (done) begin
                state_n = IDLE;
                done_ev = 1'b1;
            end
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
            else if (limit) begin
                state_n = DRAIN;
                to_ev   = 1'b1;
                tcnt_n  = '0;
            end
            DRAIN: if (tcnt == TW'(1)) state_n = IDLE;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            pending_count <= '0;
            next_id       <= '0;
            xfer_id       <= '0;
            request       <= 1'b0;
            xfer_done     <= 1'b0;
            start_drop    <= 1'b0;
        end else begin
            state         <= state_n;
            hold_cnt      <= hold_n;
            pending_count <= pend_n;
            request       <= state_n == REQ || state_n == HOLD;
            xfer_done     <= done_ev;
            start_drop    <= drop;
            if (issue) begin
                xfer_id <= next_id;
                next_id <= next_id + ID_W'(1);
            end
        end
    end

`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            tcnt        <= tcnt_n;
            timeout_err <= to_ev;
        end
    end
`else
    assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_handshake_initiator.sv
// tb_handshake_initiator: directed checks of the handshake initiator against a simple responder model.
module tb_handshake_initiator;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       accept, done_r, done, done_force = 1'b0, stall = 1'b0;
    logic       start_drop, busy, request, xfer_done, timeout_err;
    logic [2:0] pending_count;
    logic [1:0] xfer_id;
    int         vectors = 0;
    int         errors = 0;
    int         exp_ids [6] = '{0, 1, 2, 3, 0, 1};

    handshake_initiator #(.HOLD_CYCLES(2), .TIMEOUT(16), .MAX_PENDING(4), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .start_drop(start_drop),
        .pending_count(pending_count), .busy(busy), .request(request),
        .accept(accept), .done(done), .xfer_done(xfer_done), .xfer_id(xfer_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // responder: accept follows request one cycle late, done pulses once request is seen low
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            accept <= 1'b0;
            done_r <= 1'b0;
        end else begin
            accept <= request && !stall;
            done_r <= accept && !request;
        end
    end
    assign done = done_r | done_force;

    task automatic reset_dut();
        rst = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        done_force = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++;
        if ({start_drop, pending_count, busy, request, xfer_done, xfer_id, timeout_err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, want all 0",
                {start_drop, pending_count, busy, request, xfer_done, xfer_id, timeout_err});
        end
    endtask

    task automatic test_single();
        reset_dut();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            vectors++;
            if (request !== (k >= 2 && k <= 5)) begin
                errors++;
                $display("FAIL single_request edge %0d: got %b want %b", k, request, k >= 2 && k <= 5);
            end
            vectors++;
            if (xfer_done !== (k == 8) || (k == 8 && xfer_id !== 2'd0)) begin
                errors++;
                $display("FAIL single_xfer_done edge %0d: got %b id %0d want %b id 0", k, xfer_done, xfer_id, k == 8);
            end
            vectors++;
            if (busy !== (k <= 7) || pending_count !== ((k == 1) ? 3'd1 : 3'd0)) begin
                errors++;
                $display("FAIL single_busy edge %0d: got busy %b pend %0d", k, busy, pending_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int cyc = 0;
        int low_run = 0;
        logic inj = 1'b0;
        int exp_pend [6] = '{1, 1, 2, 3, 4, 4};
        reset_dut();
        stall = 1'b1;
        start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (pending_count !== 3'(exp_pend[k-1]) || start_drop !== (k == 6)) begin
                errors++;
                $display("FAIL queue_fill edge %0d: pend %0d drop %b want pend %0d drop %b",
                    k, pending_count, start_drop, exp_pend[k-1], k == 6);
            end
        end
        start = 1'b0;
        @(negedge clk);
        vectors++;
        if (start_drop !== 1'b0 || pending_count !== 3'd4) begin
            errors++;
            $display("FAIL queue_after_drop: drop %b pend %0d want 0 4", start_drop, pending_count);
        end
        stall = 1'b0;
        while (n < 6 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (inj) begin
                start = 1'b0;
                inj = 1'b0;
                vectors++;
                if (pending_count !== 3'd4 || start_drop !== 1'b0) begin
                    errors++;
                    $display("FAIL coincident_issue: pend %0d drop %b want 4 0", pending_count, start_drop);
                end
            end
            if (request) begin
                if (low_run > 0) begin
                    vectors++;
                    if (low_run != 3) begin
                        errors++;
                        $display("FAIL gap_low_cycles: got %0d want 3", low_run);
                    end
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            if (xfer_done) begin
                vectors++;
                if (xfer_id !== 2'(exp_ids[n])) begin
                    errors++;
                    $display("FAIL job_id %0d: got %0d want %0d", n, xfer_id, exp_ids[n]);
                end
                if (n == 0) begin
                    vectors++;
                    if (pending_count !== 3'd4) begin
                        errors++;
                        $display("FAIL pend_before_issue: got %0d want 4", pending_count);
                    end
                    start = 1'b1;
                    inj = 1'b1;
                end
                n++;
            end
        end
        vectors++;
        if (n != 6) begin
            errors++;
            $display("FAIL jobs_completed: got %0d want 6 within budget", n);
        end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        reset_dut();
        start = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (request !== 1'b1 || pending_count !== 3'd1) begin
            errors++;
            $display("FAIL mid_pre_reset: req %b pend %0d want 1 1", request, pending_count);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (request !== 1'b0 || busy !== 1'b0 || pending_count !== 3'd0) begin
            errors++;
            $display("FAIL mid_async_reset: req %b busy %b pend %0d want 0 0 0", request, busy, pending_count);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!xfer_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (xfer_done !== 1'b1 || xfer_id !== 2'd0) begin
            errors++;
            $display("FAIL mid_first_id: done %b id %0d want 1 0", xfer_done, xfer_id);
        end
    endtask

`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
    task automatic test_timeout();
        int cyc = 0;
        reset_dut();
        stall = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            done_force = (k == 18);
            vectors++;
            if (timeout_err !== (k == 18) || request !== (k >= 2 && k <= 17) || xfer_done !== 1'b0) begin
                errors++;
                $display("FAIL timeout edge %0d: to %b req %b done %b", k, timeout_err, request, xfer_done);
            end
            if (k == 19 || k == 20) begin
                vectors++;
                if (busy !== (k == 19)) begin
                    errors++;
                    $display("FAIL drain_busy edge %0d: got %b want %b", k, busy, k == 19);
                end
            end
            @(negedge clk);
        end
        done_force = 1'b0;
        stall = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!xfer_done && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (xfer_done !== 1'b1 || xfer_id !== 2'd1) begin
            errors++;
            $display("FAIL timeout_next_id: done %b id %0d want 1 1", xfer_done, xfer_id);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid();
`ifdef HANDSHAKE_INITIATOR_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
